// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared fetch-stage constants and sequencer state encoding
package mips_defs;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } seq_state_t;

endpackage

// File: rtl/pc_range_chk.sv
// rtl/pc_range_chk.sv - word-aligned, bounded address check (fetch or data side)
module pc_range_chk
  import mips_defs::*;
#(
  parameter logic [31:0] LO = IM_LO,
  parameter logic [31:0] HI = IM_HI
) (
  input  logic [31:0] addr,
  output logic        adel
);

  assign adel = (addr[1:0] != 2'b00) | (addr < LO) | (addr > HI);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - F-stage PC register with stall, redirect and hold buffering
module pc_sequencer
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        hold,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        d_is_bj,
  output logic [31:0] f_pc,
  output logic        f_bd,
  output logic        f_adel,
  output logic        f_flush,
  output logic        pend,
  output logic [31:0] fetch_cnt
);

  seq_state_t  state;
  logic [31:0] pend_pc;

  // A redirect (live, or buffered and now released) always squashes the F/D slot.
  assign f_flush = ~reset & ~hold & ((state == PEND) | req | eret);
  assign f_bd    = d_is_bj & ~f_flush;
  assign pend    = (state == PEND);

  pc_range_chk u_range (
    .addr (f_pc),
    .adel (f_adel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      f_pc      <= RESET_PC;
      pend_pc   <= 32'h0;
      fetch_cnt <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (hold) begin
            if (req) begin
              pend_pc <= HANDLER_PC;
              state   <= PEND;
            end else if (eret) begin
              pend_pc <= epc;
              state   <= PEND;
            end
          end else if (req) begin
            f_pc      <= HANDLER_PC;
            fetch_cnt <= fetch_cnt + 32'd1;
          end else if (eret) begin
            f_pc      <= epc;
            fetch_cnt <= fetch_cnt + 32'd1;
          end else if (!stall) begin
            f_pc      <= npc;
            fetch_cnt <= fetch_cnt + 32'd1;
          end
        end
        PEND: begin
          if (hold) begin
            // An exception outranks a buffered eret; a second eret is dropped.
            if (req) pend_pc <= HANDLER_PC;
          end else begin
            f_pc      <= req ? HANDLER_PC : pend_pc;
            fetch_cnt <= fetch_cnt + 32'd1;
            pend_pc   <= 32'h0;
            state     <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - vector table and scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, hold, req, eret, d_is_bj;
  logic [31:0] npc, epc;
  logic [31:0] f_pc, fetch_cnt;
  logic        f_bd, f_adel, f_flush, pend;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .npc       (npc),
    .stall     (stall),
    .hold      (hold),
    .req       (req),
    .eret      (eret),
    .epc       (epc),
    .d_is_bj   (d_is_bj),
    .f_pc      (f_pc),
    .f_bd      (f_bd),
    .f_adel    (f_adel),
    .f_flush   (f_flush),
    .pend      (pend),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, hld, rq, er, bj;
    logic [31:0] np, ep;
    logic        x_flush, x_bd;
    logic [31:0] x_pc;
    logic        x_pend;
    logic [31:0] x_cnt;
    logic        x_adel;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        pnd;
    logic [31:0] cnt;
    logic        adel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic rst, stl, hld, rq, er, bj, input logic [31:0] np, ep,
                   input logic xf, xb, input logic [31:0] xpc, input logic xp,
                   input logic [31:0] xc, input logic xa);
    vec_t t;
    t.rst = rst; t.stl = stl; t.hld = hld; t.rq = rq; t.er = er; t.bj = bj;
    t.np = np; t.ep = ep; t.x_flush = xf; t.x_bd = xb;
    t.x_pc = xpc; t.x_pend = xp; t.x_cnt = xc; t.x_adel = xa;
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    reset = t.rst; stall = t.stl; hold = t.hld; req = t.rq; eret = t.er;
    d_is_bj = t.bj; npc = t.np; epc = t.ep;
  endtask

  initial begin
    exp_t e;
    vec_t idle;
    int   waited;

    //  rst stl hld req ert bj  npc           epc           flush bd  f_pc after    pend cnt adel
    v(1, 0, 0, 0, 0, 0, 32'h0000_9999, 32'h0,        0, 0, 32'h0000_3000, 0, 0,  0);
    v(0, 0, 0, 0, 0, 0, 32'h0000_3004, 32'h0,        0, 0, 32'h0000_3004, 0, 1,  0);
    v(0, 0, 0, 0, 0, 0, 32'h0000_3008, 32'h0,        0, 0, 32'h0000_3008, 0, 2,  0);
    v(0, 0, 0, 0, 0, 0, 32'h0000_300C, 32'h0,        0, 0, 32'h0000_300C, 0, 3,  0);
    v(0, 0, 0, 0, 0, 0, 32'h0000_3010, 32'h0,        0, 0, 32'h0000_3010, 0, 4,  0);
    v(0, 1, 0, 0, 0, 0, 32'h0000_3014, 32'h0,        0, 0, 32'h0000_3010, 0, 4,  0);
    v(0, 1, 0, 0, 0, 0, 32'h0000_3014, 32'h0,        0, 0, 32'h0000_3010, 0, 4,  0);
    v(0, 1, 0, 0, 0, 0, 32'h0000_3014, 32'h0,        0, 0, 32'h0000_3010, 0, 4,  0);
    v(0, 0, 0, 0, 0, 0, 32'h0000_3014, 32'h0,        0, 0, 32'h0000_3014, 0, 5,  0);
    v(0, 0, 0, 0, 0, 1, 32'h0000_3018, 32'h0,        0, 1, 32'h0000_3018, 0, 6,  0);
    v(0, 0, 0, 0, 0, 0, 32'h0000_301C, 32'h0,        0, 0, 32'h0000_301C, 0, 7,  0);
    v(0, 0, 0, 0, 0, 0, 32'h0000_3020, 32'h0,        0, 0, 32'h0000_3020, 0, 8,  0);
    v(0, 1, 0, 1, 0, 1, 32'h0000_3024, 32'h0,        1, 0, 32'h0000_4180, 0, 9,  0);
    v(0, 0, 1, 0, 1, 1, 32'h0000_4184, 32'h0000_3100, 0, 1, 32'h0000_4180, 1, 9,  0);
    v(0, 0, 1, 0, 0, 0, 32'h0000_4184, 32'h0,        0, 0, 32'h0000_4180, 1, 9,  0);
    v(0, 0, 1, 1, 0, 0, 32'h0000_4184, 32'h0,        0, 0, 32'h0000_4180, 1, 9,  0);
    v(0, 0, 1, 0, 0, 0, 32'h0000_4184, 32'h0,        0, 0, 32'h0000_4180, 1, 9,  0);
    v(0, 0, 0, 0, 0, 1, 32'h0000_4184, 32'h0,        1, 0, 32'h0000_4180, 0, 10, 0);
    v(0, 0, 1, 0, 1, 0, 32'h0000_4184, 32'h0000_3100, 0, 0, 32'h0000_4180, 1, 10, 0);
    v(0, 0, 1, 0, 1, 0, 32'h0000_4184, 32'h0000_3200, 0, 0, 32'h0000_4180, 1, 10, 0);
    v(0, 0, 0, 0, 0, 0, 32'h0000_3000, 32'h0000_3300, 1, 0, 32'h0000_3100, 0, 11, 0);
    v(0, 0, 0, 0, 0, 0, 32'h0000_3002, 32'h0,        0, 0, 32'h0000_3002, 0, 12, 1);
    v(0, 0, 0, 0, 0, 0, 32'h0000_7000, 32'h0,        0, 0, 32'h0000_7000, 0, 13, 1);
    v(0, 0, 0, 0, 0, 0, 32'h0000_6FFC, 32'h0,        0, 0, 32'h0000_6FFC, 0, 14, 0);
    v(0, 0, 0, 0, 0, 0, 32'h0000_2FFC, 32'h0,        0, 0, 32'h0000_2FFC, 0, 15, 1);
    v(0, 0, 0, 0, 0, 0, 32'h0000_3000, 32'h0,        0, 0, 32'h0000_3000, 0, 16, 0);
    v(0, 0, 0, 0, 1, 0, 32'h0000_3004, 32'h0000_3040, 1, 0, 32'h0000_3040, 0, 17, 0);
    v(0, 1, 0, 0, 1, 0, 32'h0000_3044, 32'h0000_3050, 1, 0, 32'h0000_3050, 0, 18, 0);
    v(0, 0, 1, 0, 1, 0, 32'h0000_3054, 32'h0000_3060, 0, 0, 32'h0000_3050, 1, 18, 0);
    v(0, 0, 0, 1, 0, 0, 32'h0000_3054, 32'h0,        1, 0, 32'h0000_4180, 0, 19, 0);
    v(0, 0, 1, 0, 0, 0, 32'h0000_3000, 32'h0,        0, 0, 32'h0000_4180, 0, 19, 0);
    v(0, 0, 1, 1, 0, 0, 32'h0000_3000, 32'h0,        0, 0, 32'h0000_4180, 1, 19, 0);
    v(1, 0, 1, 0, 0, 0, 32'h0000_3000, 32'h0,        0, 0, 32'h0000_3000, 0, 0,  0);
    v(0, 0, 0, 0, 0, 0, 32'h0000_3004, 32'h0,        0, 0, 32'h0000_3004, 0, 1,  0);

    idle = vecs[1];
    idle.rst = 0;
    drive(idle);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      e.pc = vecs[i].x_pc; e.pnd = vecs[i].x_pend; e.cnt = vecs[i].x_cnt; e.adel = vecs[i].x_adel;
      sb.push_back(e);
      @(negedge clk);
      chk($sformatf("v%0d f_flush", i), {31'b0, f_flush}, {31'b0, vecs[i].x_flush});
      chk($sformatf("v%0d f_bd", i), {31'b0, f_bd}, {31'b0, vecs[i].x_bd});
      @(posedge clk); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d f_pc", i), f_pc, e.pc);
      chk($sformatf("v%0d pend", i), {31'b0, pend}, {31'b0, e.pnd});
      chk($sformatf("v%0d fetch_cnt", i), fetch_cnt, e.cnt);
      chk($sformatf("v%0d f_adel", i), {31'b0, f_adel}, {31'b0, e.adel});
    end

    // Long hold with a req buffered, then release and wait for the handler fetch.
    reset = 0; stall = 0; eret = 0; d_is_bj = 0; npc = 32'h0000_3008;
    hold = 1; req = 1;
    @(posedge clk); #1;
    req = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d f_flush", k), {31'b0, f_flush}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("hold%0d pend", k), {31'b0, pend}, 32'd1);
      chk($sformatf("hold%0d f_pc", k), f_pc, 32'h0000_3004);
    end
    hold = 0;
    waited = 0;
    while (f_pc !== 32'h0000_4180 && waited < 4) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("release latency", waited, 1);
    chk("release pend", {31'b0, pend}, 32'd0);
    chk("release fetch_cnt", fetch_cnt, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the F-stage PC register of the five-stage MIPS pipeline.
- Decides each cycle whether F loads the NPC candidate, holds for a stall, jumps to the exception handler, or returns to EPC on eret.
- Buffers single-cycle redirect pulses that arrive while a global hold is active, and flags delay-slot and fetch-address exceptions for the F/D register and CP0.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry address.
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- npc  in  32  next-PC candidate from the next-PC logic (branch/jump/PC+4 already resolved)
- stall  in  1  hazard stall from D stage; F holds PC
- hold  in  1  global freeze (bridge/peripheral wait); nothing advances
- req  in  1  one-cycle pulse from CP0: take exception/interrupt
- eret  in  1  one-cycle pulse: eret resolved in D
- epc  in  32  return address from CP0, valid when eret=1
- d_is_bj  in  1  D-stage instruction is branch/jump, so the F instruction is a delay slot
- f_pc  out  32  current fetch PC
- f_bd  out  1  F instruction is in a delay slot
- f_adel  out  1  fetch address exception for current f_pc
- f_flush  out  1  F/D register must load a nop this cycle
- pend  out  1  a buffered redirect is waiting
- fetch_cnt  out  32  count of accepted fetches (PC updates)

Behaviour:
- Reset (sync, high) values: f_pc=RESET_PC, pend=0, pend_pc=0, state=RUN, fetch_cnt=0, f_bd=0, f_flush=0. Reset overrides every other input in the same cycle.
- States:
  - RUN: normal operation.
  - PEND: redirect buffered during hold.
  - STALLED is not a separate state; stall is a pure hold in RUN.
- RUN, hold=0. Priority order: req > eret > stall > npc.
  - req: f_pc <= HANDLER_PC; f_flush=1.
  - eret: f_pc <= epc; f_flush=1. The instruction after eret is not executed; there is no delay slot.
  - stall: f_pc holds; f_flush=0.
  - Otherwise: f_pc <= npc.
- RUN, hold=1:
  - f_pc holds.
  - If req or eret is high, latch the target into pend_pc (req wins if both are high), assert pend, go to PEND.
- PEND, hold=1:
  - Keep pend_pc, except that a new req overwrites a latched eret target.
  - A second eret while pending is ignored.
- PEND, hold=0:
  - f_pc <= pend_pc; f_flush=1; pend <= 0; return to RUN.
  - A req arriving in this same cycle takes precedence: f_pc <= HANDLER_PC.
- fetch_cnt increments by 1, wrapping modulo 2^32, on every cycle f_pc is written by a non-reset update. It does not increment on stall or hold.
- f_adel is combinational on f_pc: it is 1 when f_pc[1:0]!=0 or f_pc<IM_LO or f_pc>IM_HI (unsigned compare).
- f_bd is combinational: f_bd = d_is_bj & ~f_flush.
- f_flush is combinational, asserted only in the cycles defined above. It is never asserted while hold=1.
- Width rules: all PCs are 32-bit unsigned; no sign extension is performed here.
- Latency: a redirect taken in cycle N appears on f_pc in cycle N+1. A buffered redirect appears one cycle after hold falls.
- Reset mid-PEND: the pending target is discarded and f_pc=RESET_PC.

Decomposition:
- Shared package (mips_defs): RESET_PC, HANDLER_PC, IM_LO and IM_HI constants, and the 1-bit state encoding (RUN=0, PEND=1).
- One natural sub-module: pc_range_chk, the combinational f_adel logic, reusable for the M-stage data address check.
- Everything else stays flat.

Test Plan:
- Reset then 4 free cycles, npc=f_pc+4 → f_pc sequence 3000, 3004, 3008, 300C, 3010; fetch_cnt=4.
- stall=1 for 3 cycles at f_pc=3010 → f_pc stays 3010, fetch_cnt unchanged; stall drops with npc=3014 → 3014.
- req pulse with stall=1 at f_pc=3020 → next f_pc=4180, f_flush=1 in the req cycle.
- hold=1, eret pulse with epc=3100, then req 2 cycles later, hold released 2 cycles after that → pend=1 throughout the hold; after release f_pc=4180 and pend=0.
- npc=3002, then npc=7000 → f_adel=1 for both; npc=6FFC → f_adel=0.
- hold=1 with pend set, then reset=1 → f_pc=3000, pend=0, fetch_cnt=0 on the next cycle.
